// File: rtl/reg_window_ctrl.sv
// Register-window frame-pointer controller.
// CALL pushes FP and advances the window; RTN pops it back.
module reg_window_ctrl #(
  parameter int DEPTH = 8
) (
  input  logic       Clock,
  input  logic       Reset_n,
  input  logic       Call_Req,
  input  logic       Rtn_Req,
  input  logic [2:0] Call_Offset,
  output logic [6:0] FP,
  output logic [6:0] New_FP,
  output logic       FP_move,
  output logic       FP_push_up,
  output logic       Busy,
  output logic       Done,
  output logic       Fault,
  output logic [3:0] Depth
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [3:0] DMAX = 4'(DEPTH);

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_CALL_PUSH = 3'd1;
  localparam logic [2:0] S_CALL_MOVE = 3'd2;
  localparam logic [2:0] S_RTN_POP   = 3'd3;
  localparam logic [2:0] S_RTN_MOVE  = 3'd4;

  logic [2:0]    state;
  logic [2:0]    off_q;
  logic [6:0]    target;
  logic [6:0]    stack [DEPTH];
  logic [7:0]    reach;
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          idle;
  logic          call_ok;
  logic          go_call;
  logic          go_rtn;
  logic          reject;

  // The top of the new window must stay inside the 128-entry file.
  assign reach   = {1'b0, FP} + {5'b0, Call_Offset} + 8'd7;
  assign call_ok = (Depth < DMAX) && (Call_Offset != 3'd0)
                && (reach <= 8'd127);

  assign idle    = (state == S_IDLE);
  assign go_call = idle && Call_Req && !Rtn_Req && call_ok;
  assign go_rtn  = idle && Rtn_Req && !Call_Req && (Depth != 4'd0);
  assign reject  = idle && (Call_Req || Rtn_Req) && !go_call && !go_rtn;

  assign wr_ptr = AW'(Depth);
  assign rd_ptr = AW'(Depth - 4'd1);

  assign FP_move    = (state == S_CALL_MOVE) || (state == S_RTN_MOVE);
  assign FP_push_up = (state == S_CALL_MOVE);
  assign New_FP     = FP_move ? target : FP;
  assign Busy       = !idle;

  // Stack storage needs no reset; Depth gates all reads.
  always_ff @(posedge Clock) begin
    if (state == S_CALL_PUSH) stack[wr_ptr] <= FP;
  end

  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      state  <= S_IDLE;
      FP     <= 7'd0;
      Depth  <= 4'd0;
      target <= 7'd0;
      off_q  <= 3'd0;
      Done   <= 1'b0;
      Fault  <= 1'b0;
    end else begin
      Done  <= 1'b0;
      Fault <= 1'b0;
      unique case (state)
        S_IDLE: begin
          Fault <= reject;
          if (go_call) begin
            off_q <= Call_Offset;
            state <= S_CALL_PUSH;
          end else if (go_rtn) begin
            state <= S_RTN_POP;
          end
        end
        S_CALL_PUSH: begin
          Depth  <= Depth + 4'd1;
          target <= FP + {4'b0, off_q};
          state  <= S_CALL_MOVE;
        end
        S_RTN_POP: begin
          Depth  <= Depth - 4'd1;
          target <= stack[rd_ptr];
          state  <= S_RTN_MOVE;
        end
        S_CALL_MOVE, S_RTN_MOVE: begin
          FP    <= target;
          Done  <= 1'b1;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_reg_window_ctrl.sv
// Randomised bench for reg_window_ctrl.
// Reference model: a queue of saved frame pointers.
module tb_reg_window_ctrl;

  localparam int DEPTH = 8;

  logic       Clock = 1'b0;
  logic       Reset_n;
  logic       Call_Req = 1'b0;
  logic       Rtn_Req = 1'b0;
  logic [2:0] Call_Offset = 3'd0;
  logic [6:0] FP;
  logic [6:0] New_FP;
  logic       FP_move;
  logic       FP_push_up;
  logic       Busy;
  logic       Done;
  logic       Fault;
  logic [3:0] Depth;

  reg_window_ctrl #(.DEPTH(DEPTH)) dut (
    .Clock(Clock),
    .Reset_n(Reset_n),
    .Call_Req(Call_Req),
    .Rtn_Req(Rtn_Req),
    .Call_Offset(Call_Offset),
    .FP(FP),
    .New_FP(New_FP),
    .FP_move(FP_move),
    .FP_push_up(FP_push_up),
    .Busy(Busy),
    .Done(Done),
    .Fault(Fault),
    .Depth(Depth)
  );

  always #5 Clock = ~Clock;

  int checks = 0;
  int errors = 0;
  int stk[$];
  int fp_m = 0;

  logic [22:0] obs;
  assign obs = {FP, New_FP, FP_move, FP_push_up, Busy, Done, Fault, Depth};

  function automatic logic [22:0] pack(int fp, int nfp, bit mv, bit up,
                                       bit busy, bit done, bit fault,
                                       int d);
    return {7'(fp), 7'(nfp), mv, up, busy, done, fault, 4'(d)};
  endfunction

  task automatic apply_reset();
    Call_Req = 0;
    Rtn_Req = 0;
    Reset_n = 0;
    #2;
    stk.delete();
    fp_m = 0;
    @(posedge Clock);
    #3;
    Reset_n = 1;
  endtask

  task automatic run_op(input bit c, input bit r, input logic [2:0] off);
    int d0 = stk.size();
    int f0 = fp_m;
    int tgt;
    bit acc = 0;
    bit flt = 0;
    logic [22:0] exp;
    if (c && r) flt = 1;
    else if (c) begin
      if (d0 < DEPTH && off != 0 && f0 + int'(off) + 7 <= 127) acc = 1;
      else flt = 1;
    end else if (r) begin
      if (d0 > 0) acc = 1;
      else flt = 1;
    end
    Call_Req = c;
    Rtn_Req = r;
    Call_Offset = off;
    @(posedge Clock);
    #1;
    Call_Req = 0;
    Rtn_Req = 0;
    Call_Offset = 3'($urandom);
    if (!acc) begin
      exp = pack(f0, f0, 0, 0, 0, 0, flt, d0);
      checks++;
      if (obs !== exp) begin
        errors++;
        $display("FAIL reject c=%0d r=%0d off=%0d got %h exp %h",
                 c, r, off, obs, exp);
      end
      return;
    end
    exp = pack(f0, f0, 0, 0, 1, 0, 0, d0);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL push_state got %h exp %h", obs, exp);
    end
    if (c) begin
      tgt = f0 + int'(off);
      stk.push_back(f0);
    end else begin
      tgt = stk.pop_back();
    end
    @(posedge Clock);
    #1;
    exp = pack(f0, tgt, 1, c, 1, 0, 0, stk.size());
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL move c=%0d got %h exp %h", c, obs, exp);
    end
    @(posedge Clock);
    #1;
    fp_m = tgt;
    exp = pack(tgt, tgt, 0, 0, 0, 1, 0, stk.size());
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL done c=%0d got %h exp %h", c, obs, exp);
    end
  endtask

  task automatic test_reset();
    Reset_n = 0;
    #3;
    checks++;
    if (obs !== 23'd0) begin
      errors++;
      $display("FAIL reset got %h exp %h", obs, 23'd0);
    end
    stk.delete();
    fp_m = 0;
    @(posedge Clock);
    #3;
    Reset_n = 1;
  endtask

  task automatic test_call_basic();
    run_op(1, 0, 3);
    checks++;
    if (FP !== 7'd3 || Depth !== 4'd1) begin
      errors++;
      $display("FAIL basic_call got fp=%0d d=%0d exp fp=3 d=1", FP, Depth);
    end
  endtask

  task automatic test_nested();
    apply_reset();
    run_op(1, 0, 3);
    run_op(1, 0, 5);
    checks++;
    if (FP !== 7'd8) begin
      errors++;
      $display("FAIL nested_fp got %0d exp 8", FP);
    end
    run_op(0, 1, 0);
    run_op(0, 1, 0);
    checks++;
    if (FP !== 7'd0 || Depth !== 4'd0) begin
      errors++;
      $display("FAIL nested_end got fp=%0d d=%0d exp 0 0", FP, Depth);
    end
  endtask

  task automatic test_faults();
    apply_reset();
    run_op(0, 1, 0);
    run_op(0, 0, 0);
    run_op(1, 0, 0);
    run_op(0, 0, 0);
    run_op(1, 1, 2);
    run_op(0, 0, 0);
  endtask

  task automatic test_overflow();
    apply_reset();
    for (int i = 0; i < DEPTH; i++) run_op(1, 0, 1);
    run_op(1, 0, 1);
    checks++;
    if (FP !== 7'd8 || Depth !== 4'd8) begin
      errors++;
      $display("FAIL overflow got fp=%0d d=%0d exp 8 8", FP, Depth);
    end
    run_op(0, 0, 0);
  endtask

  task automatic test_hold_busy();
    int f0;
    int seen_fault = 0;
    apply_reset();
    run_op(1, 0, 4);
    f0 = fp_m;
    Call_Req = 1;
    Call_Offset = 3'd2;
    for (int i = 0; i < 3; i++) begin
      @(posedge Clock);
      #1;
      Call_Offset = 3'd7;
      if (Fault) seen_fault++;
    end
    Call_Req = 0;
    stk.push_back(f0);
    fp_m = f0 + 2;
    checks++;
    if (seen_fault != 0 || FP !== 7'(fp_m) || Depth !== 4'd2 || !Done) begin
      errors++;
      $display("FAIL hold got fp=%0d d=%0d flt=%0d exp fp=%0d d=2 flt=0",
               FP, Depth, seen_fault, fp_m);
    end
    @(posedge Clock);
    #1;
    checks++;
    if (obs !== pack(fp_m, fp_m, 0, 0, 0, 0, 0, 2)) begin
      errors++;
      $display("FAIL hold_after got %h exp %h", obs,
               pack(fp_m, fp_m, 0, 0, 0, 0, 0, 2));
    end
  endtask

  task automatic test_reset_mid();
    int dones = 0;
    apply_reset();
    Call_Req = 1;
    Call_Offset = 3'd3;
    @(posedge Clock);
    #1;
    Call_Req = 0;
    @(posedge Clock);
    #1;
    checks++;
    if (FP_move !== 1'b1) begin
      errors++;
      $display("FAIL mid_move got %b exp 1", FP_move);
    end
    #2;
    Reset_n = 0;
    #1;
    checks++;
    if (obs !== 23'd0) begin
      errors++;
      $display("FAIL mid_reset got %h exp %h", obs, 23'd0);
    end
    stk.delete();
    fp_m = 0;
    @(posedge Clock);
    #2;
    Reset_n = 1;
    for (int i = 0; i < 3; i++) begin
      @(posedge Clock);
      #1;
      if (Done || obs !== 23'd0) dones++;
    end
    checks++;
    if (dones != 0) begin
      errors++;
      $display("FAIL mid_no_done got %0d bad cycles exp 0", dones);
    end
    run_op(1, 0, 6);
  endtask

  task automatic test_random();
    int k;
    apply_reset();
    for (int n = 0; n < 150; n++) begin
      k = $urandom_range(0, 9);
      if (k < 5) run_op(1, 0, 3'($urandom_range(0, 7)));
      else if (k < 8) run_op(0, 1, 3'($urandom));
      else if (k == 8) run_op(1, 1, 3'($urandom));
      else run_op(0, 0, 3'($urandom));
    end
  endtask

  initial begin
    test_reset();
    test_call_basic();
    test_nested();
    test_faults();
    test_overflow();
    test_hold_busy();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
